// File: rtl/vexriscv_bus_arbiter.sv
// rtl/vexriscv_bus_arbiter.sv - round-robin iBus/dBus arbiter onto one memory port
// Read responses are routed back through an in-order source-ID FIFO.
module vexriscv_bus_arbiter #(
   parameter int PENDING_DEPTH = 4,
   parameter int ADDR_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iBus_cmd_valid,
   output logic                  iBus_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] iBus_cmd_payload_pc,
   output logic                  iBus_rsp_ready,
   output logic [31:0]           iBus_rsp_inst,
   output logic                  iBus_rsp_error,
   input  logic                  dBus_cmd_valid,
   output logic                  dBus_cmd_ready,
   input  logic                  dBus_cmd_payload_wr,
   input  logic [ADDR_WIDTH-1:0] dBus_cmd_payload_address,
   input  logic [31:0]           dBus_cmd_payload_data,
   input  logic [1:0]            dBus_cmd_payload_size,
   output logic                  dBus_rsp_ready,
   output logic [31:0]           dBus_rsp_data,
   output logic                  dBus_rsp_error,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic                  mem_cmd_wr,
   output logic [ADDR_WIDTH-1:0] mem_cmd_address,
   output logic [31:0]           mem_cmd_data,
   output logic [1:0]            mem_cmd_size,
   input  logic                  mem_rsp_valid,
   input  logic [31:0]           mem_rsp_data,
   input  logic                  mem_rsp_error,
   output logic                  protocol_err
);
   localparam int PW = $clog2(PENDING_DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(PENDING_DEPTH);

   logic [PENDING_DEPTH-1:0] srcFifo;
   logic [PW-1:0]            wrPtr, rdPtr;
   logic [PW:0]              count;
   logic                     lastGrantD, locked, lockedD, protocolErr;
   logic                     full, iOffer, dOffer, grantD, memValid, fire, push, pop, head;

   // A same-cycle pop does not free a slot: full is judged on the registered count.
   always_comb begin
      full     = (count == FULL_COUNT);
      iOffer   = !reset && iBus_cmd_valid && !full;
      dOffer   = !reset && dBus_cmd_valid && (dBus_cmd_payload_wr || !full);
      grantD   = 1'b0;
      memValid = 1'b0;
      if (locked) begin
         grantD   = lockedD;
         memValid = lockedD ? dOffer : iOffer;
      end else begin
         grantD   = (iOffer && dOffer) ? !lastGrantD : dOffer;
         memValid = iOffer || dOffer;
      end
      fire = memValid && mem_cmd_ready;
      push = fire && (!grantD || !dBus_cmd_payload_wr);
      pop  = !reset && mem_rsp_valid && (count != '0);
      head = srcFifo[rdPtr];
   end

   assign mem_cmd_valid   = memValid;
   assign mem_cmd_wr      = grantD && dBus_cmd_payload_wr;
   assign mem_cmd_address = grantD ? dBus_cmd_payload_address : iBus_cmd_payload_pc;
   assign mem_cmd_data    = grantD ? dBus_cmd_payload_data : 32'd0;
   assign mem_cmd_size    = grantD ? dBus_cmd_payload_size : 2'd2;
   assign iBus_cmd_ready  = fire && !grantD;
   assign dBus_cmd_ready  = fire && grantD;
   assign iBus_rsp_ready  = pop && !head;
   assign dBus_rsp_ready  = pop && head;
   assign iBus_rsp_inst   = mem_rsp_data;
   assign dBus_rsp_data   = mem_rsp_data;
   assign iBus_rsp_error  = mem_rsp_error;
   assign dBus_rsp_error  = mem_rsp_error;
   assign protocol_err    = protocolErr;

   always_ff @(posedge clk) begin
      if (reset) begin
         lastGrantD  <= 1'b1;
         locked      <= 1'b0;
         lockedD     <= 1'b0;
         wrPtr       <= '0;
         rdPtr       <= '0;
         count       <= '0;
         protocolErr <= 1'b0;
      end else begin
         locked  <= memValid && !mem_cmd_ready;
         lockedD <= grantD;
         if (fire)
            lastGrantD <= grantD;
         if (push) begin
            srcFifo[wrPtr] <= grantD;
            wrPtr          <= wrPtr + PW'(1);
         end
         if (pop)
            rdPtr <= rdPtr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (mem_rsp_valid && count == '0)
            protocolErr <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vexriscv_bus_arbiter.sv
// tb/tb_vexriscv_bus_arbiter.sv - directed and random checks against a queue-based model
module tb_vexriscv_bus_arbiter;
   logic clk = 1'b0;
   logic reset;
   logic iValid, dValid, dWr, memReady, rspValid, rspErr;
   logic [31:0] iPc, dAddr, dData, rspData;
   logic [1:0] dSize;
   logic iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_error, dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error;
   logic mem_cmd_valid, mem_cmd_wr, protocol_err;
   logic [31:0] iBus_rsp_inst, dBus_rsp_data, mem_cmd_address, mem_cmd_data;
   logic [1:0] mem_cmd_size;

   int checks = 0;
   int errors = 0;

   // Model state: outstanding read sources (0=iBus,1=dBus), last winner, held bus (-1 none).
   int pend[$];
   int lastWinner = 1;
   int heldBus = -1;
   bit perrModel = 0;
   bit iAcc, dAcc;

   always #5 clk = ~clk;

   vexriscv_bus_arbiter #(.PENDING_DEPTH(4), .ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .iBus_cmd_valid(iValid), .iBus_cmd_ready(iBus_cmd_ready), .iBus_cmd_payload_pc(iPc),
      .iBus_rsp_ready(iBus_rsp_ready), .iBus_rsp_inst(iBus_rsp_inst), .iBus_rsp_error(iBus_rsp_error),
      .dBus_cmd_valid(dValid), .dBus_cmd_ready(dBus_cmd_ready), .dBus_cmd_payload_wr(dWr),
      .dBus_cmd_payload_address(dAddr), .dBus_cmd_payload_data(dData), .dBus_cmd_payload_size(dSize),
      .dBus_rsp_ready(dBus_rsp_ready), .dBus_rsp_data(dBus_rsp_data), .dBus_rsp_error(dBus_rsp_error),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(memReady), .mem_cmd_wr(mem_cmd_wr),
      .mem_cmd_address(mem_cmd_address), .mem_cmd_data(mem_cmd_data), .mem_cmd_size(mem_cmd_size),
      .mem_rsp_valid(rspValid), .mem_rsp_data(rspData), .mem_rsp_error(rspErr),
      .protocol_err(protocol_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at the falling edge with inputs driven; checks outputs, then advances one cycle.
   task automatic tick();
      bit iWants, dWants, offered, popNow;
      int winner, headId;
      #1;
      iWants = !reset && iValid && pend.size() < 4;
      dWants = !reset && dValid && (dWr || pend.size() < 4);
      if (heldBus >= 0) begin
         winner  = heldBus;
         offered = (winner == 1) ? dWants : iWants;
      end else begin
         offered = iWants || dWants;
         if (iWants && dWants) winner = 1 - lastWinner;
         else                  winner = dWants ? 1 : 0;
      end
      check("mem_cmd_valid", mem_cmd_valid, offered);
      if (offered) begin
         check("mem_cmd_address", mem_cmd_address, winner == 1 ? dAddr : iPc);
         check("mem_cmd_wr", mem_cmd_wr, winner == 1 ? dWr : 1'b0);
         check("mem_cmd_data", mem_cmd_data, winner == 1 ? dData : 32'd0);
         check("mem_cmd_size", mem_cmd_size, winner == 1 ? dSize : 2'd2);
      end
      iAcc = offered && memReady && winner == 0;
      dAcc = offered && memReady && winner == 1;
      check("iBus_cmd_ready", iBus_cmd_ready, iAcc);
      check("dBus_cmd_ready", dBus_cmd_ready, dAcc);
      popNow = !reset && rspValid && pend.size() > 0;
      headId = popNow ? pend[0] : -1;
      check("iBus_rsp_ready", iBus_rsp_ready, headId == 0);
      check("dBus_rsp_ready", dBus_rsp_ready, headId == 1);
      check("iBus_rsp_inst", iBus_rsp_inst, rspData);
      check("dBus_rsp_data", dBus_rsp_data, rspData);
      check("rsp_error", {iBus_rsp_error, dBus_rsp_error}, {rspErr, rspErr});
      check("protocol_err", protocol_err, perrModel);
      @(posedge clk);
      if (reset) begin
         pend.delete();
         lastWinner = 1;
         heldBus = -1;
         perrModel = 0;
         iAcc = 0;
         dAcc = 0;
      end else begin
         if (rspValid && pend.size() == 0) perrModel = 1;
         if (popNow) void'(pend.pop_front());
         if (iAcc || dAcc) begin
            lastWinner = winner;
            if (iAcc || !dWr) pend.push_back(winner);
         end
         heldBus = (offered && !memReady) ? winner : -1;
      end
      @(negedge clk);
   endtask

   task automatic idleInputs();
      iValid = 0; dValid = 0; dWr = 0; memReady = 0; rspValid = 0; rspErr = 0;
      iPc = 0; dAddr = 0; dData = 0; dSize = 0; rspData = 0;
   endtask

   task automatic doReset();
      idleInputs();
      reset = 1;
      tick();
      reset = 0;
   endtask

   initial begin
      idleInputs();
      reset = 1;
      @(negedge clk);
      #1;
      check("reset mem_cmd_valid", mem_cmd_valid, 1'b0);
      tick();
      reset = 0;
      check("reset protocol_err", protocol_err, 1'b0);

      // Single fetch with response on the following cycle
      iValid = 1; iPc = 32'h100; memReady = 1;
      #1 check("t1 iBus_cmd_ready", iBus_cmd_ready, 1'b1);
      tick();
      iValid = 0; rspValid = 1; rspData = 32'h13;
      #1 check("t1 iBus_rsp_ready", {iBus_rsp_ready, dBus_rsp_ready, iBus_rsp_inst}, {2'b10, 32'h13});
      tick();
      rspValid = 0;

      // Both buses reading: grants alternate I,D,I,D and responses follow
      doReset();
      iValid = 1; dValid = 1; dWr = 0; memReady = 1;
      for (int k = 0; k < 4; k++) begin
         iPc = 32'h1000 + k * 4; dAddr = 32'h2000 + k * 4;
         #1 check("t2 grant", {iBus_cmd_ready, dBus_cmd_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
         tick();
      end
      iValid = 0; dValid = 0;
      for (int k = 0; k < 4; k++) begin
         rspValid = 1; rspData = 32'hA0 + k;
         #1 check("t2 route", {iBus_rsp_ready, dBus_rsp_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
         tick();
      end
      rspValid = 0;

      // dBus write held through backpressure while iBus waits
      doReset();
      dValid = 1; dWr = 1; dAddr = 32'h200; dData = 32'hDEADBEEF; dSize = 2; memReady = 0;
      tick();
      iValid = 1; iPc = 32'h300;
      for (int k = 0; k < 2; k++) begin
         #1 check("t3 held", {mem_cmd_wr, mem_cmd_address}, {1'b1, 32'h200});
         tick();
      end
      memReady = 1;
      #1 check("t3 dBus accepted", {dBus_cmd_ready, iBus_cmd_ready}, 2'b10);
      tick();
      dValid = 0;
      #1 check("t3 iBus next", iBus_cmd_ready, 1'b1);
      tick();
      iValid = 0;

      // Four reads fill the FIFO; a fifth is stalled, writes still pass
      doReset();
      iValid = 1; memReady = 1;
      for (int k = 0; k < 4; k++) begin
         iPc = 32'h400 + k * 4;
         tick();
      end
      #1 check("t4 stalled", mem_cmd_valid, 1'b0);
      tick();
      dValid = 1; dWr = 1; dAddr = 32'h500; dData = 32'h5;
      #1 check("t4 write passes", {dBus_cmd_ready, iBus_cmd_ready}, 2'b10);
      tick();
      dValid = 0; rspValid = 1; rspData = 32'h77;
      #1 check("t4 pop no unblock", {mem_cmd_valid, iBus_rsp_ready}, 2'b01);
      tick();
      rspValid = 0;
      #1 check("t4 slot freed", iBus_cmd_ready, 1'b1);
      tick();
      iValid = 0;

      // Response with nothing outstanding
      doReset();
      rspValid = 1; rspData = 32'hBAD;
      #1 check("t5 no pulse", {iBus_rsp_ready, dBus_rsp_ready}, 2'b00);
      tick();
      rspValid = 0;
      tick();
      check("t5 sticky", protocol_err, 1'b1);

      // Reset with reads in flight
      doReset();
      iValid = 1; memReady = 1;
      tick();
      tick();
      reset = 1;
      #1 check("t6 reset outputs", {mem_cmd_valid, iBus_cmd_ready, dBus_cmd_ready}, 3'b000);
      tick();
      reset = 0; iValid = 0; rspValid = 1;
      tick();
      rspValid = 0;
      #1 check("t6 late rsp", protocol_err, 1'b1);
      tick();

      // Randomized traffic; requests stay asserted until accepted
      doReset();
      for (int n = 0; n < 3000; n++) begin
         if (iAcc || !iValid) begin
            iValid = ($urandom % 3) == 0;
            iPc = $urandom;
         end
         if (dAcc || !dValid) begin
            dValid = ($urandom % 3) == 0;
            dWr = $urandom % 2;
            dAddr = $urandom;
            dData = $urandom;
            dSize = 2'($urandom % 3);
         end
         memReady = ($urandom % 4) != 0;
         rspValid = (pend.size() > 0) ? 1'($urandom % 2) : (($urandom % 60) == 0);
         rspData = $urandom;
         rspErr = ($urandom % 8) == 0;
         reset = ($urandom % 300) == 0;
         tick();
      end
      reset = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
